// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C write/read target.
// The I2C_TGT_GLITCH_FILT_EN build option only affects i2c_sync_edge.
package i2c_pkg;

   localparam int   BYTE_W    = 8;
   localparam int   CNT_W     = 4;
   localparam logic DIR_WRITE = 1'b1;
   localparam logic ACK       = 1'b0;
   localparam logic NACK      = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_WR_DATA,
      ST_WR_ACK,
      ST_RD_DATA,
      ST_RD_ACK,
      ST_WAIT_STOP
   } state_t;

   // Per-cycle datapath controls produced by the FSM output decode.
   typedef struct packed {
      logic sda_drv;
      logic cnt_clr;
      logic cnt_inc;
      logic shift_en;
      logic rx_load;
      logic tx_load;
      logic dir_load;
      logic busy_set;
      logic busy_clr;
   } ctrl_t;

   function automatic logic addr_match(input logic [BYTE_W-1:0] addr_byte,
                                       input logic [6:0]        dev_addr);
      return (addr_byte[BYTE_W-1:1] == dev_addr);
   endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchroniser with rise/fall strobes for one bus line.
// With I2C_TGT_GLITCH_FILT_EN a 3-sample majority filter follows the synchroniser.
module i2c_sync_edge (
   input  logic CLK,
   input  logic RST_N,
   input  logic din,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [1:0] sync_q;
   logic       lvl;
   logic       lvl_prev_q;

   // The idle bus level is high, so everything resets to 1.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], din};
      end
   end

`ifdef I2C_TGT_GLITCH_FILT_EN
   logic [1:0] hist_q;
   logic       filt_q;
   logic       maj;

   assign maj = (sync_q[1] & hist_q[0]) | (sync_q[1] & hist_q[1]) |
                (hist_q[0] & hist_q[1]);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         hist_q <= 2'b11;
         filt_q <= 1'b1;
      end else begin
         hist_q <= {hist_q[0], sync_q[1]};
         filt_q <= maj;
      end
   end

   assign lvl = filt_q;
`else
   assign lvl = sync_q[1];
`endif

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         lvl_prev_q <= 1'b1;
      end else begin
         lvl_prev_q <= lvl;
      end
   end

   assign q    = lvl;
   assign rise = lvl & ~lvl_prev_q;
   assign fall = ~lvl & lvl_prev_q;

endmodule

// File: rtl/i2c_target_rx.sv
// I2C target: 7-bit address match, LSB-first write capture and read return.
// Build option I2C_TGT_GLITCH_FILT_EN enables the line glitch filter in i2c_sync_edge.
//
// state        | meaning
// ST_IDLE      | bus free or after reset, waiting for START
// ST_ADDR      | shifting in the address byte
// ST_ADDR_ACK  | address matched, holding ACK for one SCL low/high period
// ST_WR_DATA   | shifting in a write data byte
// ST_WR_ACK    | holding ACK after a received data byte
// ST_RD_DATA   | driving a read byte onto SDA
// ST_RD_ACK    | sampling the master ACK/NACK after a read byte
// ST_WAIT_STOP | not addressed or NACKed, ignoring bus until START/STOP
module i2c_target_rx
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = 7'h2A
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        SCL,
   inout  wire         SDA,
   output logic [7:0]  Rx_Data,
   output logic        Rx_Valid,
   input  logic [7:0]  Tx_Data,
   output logic        Tx_Req,
   output logic        Busy
);

   logic scl_q, scl_rise, scl_fall;
   logic sda_q, sda_rise, sda_fall;

   i2c_sync_edge u_scl_sync (
      .CLK   (CLK),
      .RST_N (RST_N),
      .din   (SCL),
      .q     (scl_q),
      .rise  (scl_rise),
      .fall  (scl_fall)
   );

   i2c_sync_edge u_sda_sync (
      .CLK   (CLK),
      .RST_N (RST_N),
      .din   (SDA),
      .q     (sda_q),
      .rise  (sda_rise),
      .fall  (sda_fall)
   );

   state_t             state_q, state_d;
   ctrl_t              ctrl;
   logic [CNT_W-1:0]   bit_cnt_q;
   logic [BYTE_W-1:0]  shreg_q;
   logic [BYTE_W-1:0]  tx_sh_q;
   logic [BYTE_W-1:0]  shift_in;
   logic               dir_q;
   logic               sda_drv_q;
   logic               start_det, stop_det;
   logic               last_bit, byte_done, addr_hit;

   assign start_det = sda_fall & scl_q;
   assign stop_det  = sda_rise & scl_q;

   // LSB first: the first bus bit ends up in bit 0 after eight right shifts.
   assign shift_in  = {sda_q, shreg_q[BYTE_W-1:1]};
   assign last_bit  = (bit_cnt_q == CNT_W'(BYTE_W - 1));
   assign byte_done = (bit_cnt_q == CNT_W'(BYTE_W));
   assign addr_hit  = addr_match(shift_in, DEV_ADDR);

   assign SDA = sda_drv_q ? 1'b0 : 1'bz;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (stop_det) begin
         state_d = ST_IDLE;
      end else if (start_det) begin
         state_d = ST_ADDR;
      end else begin
         case (state_q)
            ST_ADDR: begin
               if (scl_rise && last_bit) begin
                  state_d = addr_hit ? ST_ADDR_ACK : ST_WAIT_STOP;
               end
            end
            // An active drive marks the second SCL fall, which ends the ACK.
            ST_ADDR_ACK: begin
               if (scl_fall && sda_drv_q) begin
                  state_d = (dir_q == DIR_WRITE) ? ST_WR_DATA : ST_RD_DATA;
               end
            end
            ST_WR_ACK: begin
               if (scl_fall && sda_drv_q) begin
                  state_d = ST_WR_DATA;
               end
            end
            ST_WR_DATA: begin
               if (scl_rise && last_bit) begin
                  state_d = ST_WR_ACK;
               end
            end
            ST_RD_DATA: begin
               if (scl_fall && byte_done) begin
                  state_d = ST_RD_ACK;
               end
            end
            ST_RD_ACK: begin
               if (scl_rise) begin
                  state_d = (sda_q == NACK) ? ST_WAIT_STOP : ST_RD_DATA;
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   always_comb begin
      ctrl         = '0;
      ctrl.sda_drv = sda_drv_q;
      if (stop_det) begin
         ctrl.sda_drv  = 1'b0;
         ctrl.cnt_clr  = 1'b1;
         ctrl.busy_clr = 1'b1;
      end else if (start_det) begin
         ctrl.sda_drv = 1'b0;
         ctrl.cnt_clr = 1'b1;
      end else begin
         case (state_q)
            ST_ADDR: begin
               if (scl_rise) begin
                  ctrl.shift_en = 1'b1;
                  ctrl.cnt_inc  = 1'b1;
                  if (last_bit) begin
                     ctrl.cnt_clr  = 1'b1;
                     ctrl.dir_load = 1'b1;
                     ctrl.busy_set = addr_hit;
                  end
               end
            end
            ST_ADDR_ACK: begin
               if (scl_fall) begin
                  if (!sda_drv_q) begin
                     ctrl.sda_drv = ~ACK;
                  end else if (dir_q == DIR_WRITE) begin
                     ctrl.sda_drv = 1'b0;
                  end else begin
                     // Read bit 0 must appear on this same fall, straight from Tx_Data.
                     ctrl.sda_drv = ~Tx_Data[0];
                     ctrl.tx_load = 1'b1;
                  end
               end
            end
            ST_WR_ACK: begin
               if (scl_fall) begin
                  ctrl.sda_drv = ~sda_drv_q;
               end
            end
            ST_WR_DATA: begin
               ctrl.sda_drv = 1'b0;
               if (scl_rise) begin
                  ctrl.shift_en = 1'b1;
                  ctrl.cnt_inc  = 1'b1;
                  if (last_bit) begin
                     ctrl.cnt_clr = 1'b1;
                     ctrl.rx_load = 1'b1;
                  end
               end
            end
            ST_RD_DATA: begin
               if (scl_rise) begin
                  ctrl.cnt_inc = 1'b1;
               end else if (scl_fall) begin
                  if (byte_done) begin
                     ctrl.sda_drv = 1'b0;
                     ctrl.cnt_clr = 1'b1;
                  end else begin
                     ctrl.sda_drv = ~tx_sh_q[bit_cnt_q[2:0]];
                  end
               end
            end
            ST_RD_ACK: begin
               ctrl.sda_drv = 1'b0;
               if (scl_rise && (sda_q == ACK)) begin
                  ctrl.tx_load = 1'b1;
               end
            end
            default: begin
               ctrl.sda_drv = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sda_drv_q <= 1'b0;
         bit_cnt_q <= '0;
         shreg_q   <= '0;
         tx_sh_q   <= '0;
         dir_q     <= 1'b0;
         Rx_Data   <= '0;
         Rx_Valid  <= 1'b0;
         Tx_Req    <= 1'b0;
         Busy      <= 1'b0;
      end else begin
         sda_drv_q <= ctrl.sda_drv;
         Rx_Valid  <= ctrl.rx_load;
         Tx_Req    <= ctrl.tx_load;
         if (ctrl.cnt_clr) begin
            bit_cnt_q <= '0;
         end else if (ctrl.cnt_inc) begin
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
         end
         if (ctrl.shift_en) begin
            shreg_q <= shift_in;
         end
         if (ctrl.rx_load) begin
            Rx_Data <= shift_in;
         end
         if (ctrl.tx_load) begin
            tx_sh_q <= Tx_Data;
         end
         if (ctrl.dir_load) begin
            dir_q <= shift_in[0];
         end
         if (ctrl.busy_clr) begin
            Busy <= 1'b0;
         end else if (ctrl.busy_set) begin
            Busy <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed bench for i2c_target_rx: bus-level master model with receive/read scoreboards.
`timescale 1ns/1ps
module tb_i2c_target_rx;
   import i2c_pkg::*;

   localparam int Q = 80;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic [7:0] tx_data = 8'h00;
   wire        sda;
   logic [7:0] rx_data;
   logic       rx_valid, tx_req, busy;

   int compared   = 0;
   int mismatched = 0;
   int rx_valid_cnt = 0, tx_req_cnt = 0, dut_low_cnt = 0, illegal_cnt = 0;
   int v0, t0, d0;
   logic saw_addr = 1'b0;
   logic exp_glitch;
   logic scl_prev = 1'b1, sda_prev = 1'b1, sda_m_prev = 1'b1;
   logic [7:0] rx_q[$];
   logic [7:0] rd_q[$];
   logic [7:0] rx_exp;
   logic [7:0] byte66 = 8'h66;

   assign sda = sda_m ? 1'bz : 1'b0;
   pullup (sda);

   i2c_target_rx #(.DEV_ADDR(7'h2A)) dut (
      .CLK      (clk),
      .RST_N    (rst_n),
      .SCL      (scl_m),
      .SDA      (sda),
      .Rx_Data  (rx_data),
      .Rx_Valid (rx_valid),
      .Tx_Data  (tx_data),
      .Tx_Req   (tx_req),
      .Busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Monitor: pops the receive scoreboard on Rx_Valid and watches the SDA line.
   always @(negedge clk) begin
      if (rx_valid) begin
         rx_valid_cnt++;
         compared++;
         assert (rx_q.size() > 0) else begin
            mismatched++;
            $error("FAIL rx_unexpected: observed Rx_Valid with %0h expected no pulse", rx_data);
         end
         if (rx_q.size() > 0) begin
            rx_exp = rx_q.pop_front();
            check("rx_data", 32'(rx_data), 32'(rx_exp));
         end
      end
      if (tx_req) tx_req_cnt++;
      if (sda_m && (sda === 1'b0)) dut_low_cnt++;
      if (scl_prev && scl_m && (sda !== sda_prev) && (sda_m == sda_m_prev)) illegal_cnt++;
      if (dut.state_q == ST_ADDR) saw_addr = 1'b1;
      scl_prev   = scl_m;
      sda_prev   = sda;
      sda_m_prev = sda_m;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic send_bit(input logic b);
      #Q sda_m = b;
      #Q scl_m = 1'b1;
      #Q;
      #Q scl_m = 1'b0;
   endtask

   task automatic ack_slot(input string tag, input logic exp_ack);
      #Q sda_m = 1'b1;
      #Q scl_m = 1'b1;
      #Q check(tag, 32'(sda), 32'(exp_ack));
      #Q scl_m = 1'b0;
   endtask

   task automatic write_byte(input string tag, input logic [7:0] b, input logic exp_ack);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      ack_slot(tag, exp_ack);
   endtask

   task automatic read_byte(input string tag, input logic master_ack);
      logic [7:0] got;
      logic [7:0] exp;
      got = '0;
      for (int i = 0; i < 8; i++) begin
         #Q sda_m = 1'b1;
         #Q scl_m = 1'b1;
         #Q got[i] = sda;
         #Q scl_m = 1'b0;
      end
      send_bit(master_ack);
      exp = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hxx;
      check(tag, 32'(got), 32'(exp));
   endtask

   task automatic start_cond();
      #Q sda_m = 1'b1;
      #Q scl_m = 1'b1;
      #Q sda_m = 1'b0;
      #Q scl_m = 1'b0;
   endtask

   task automatic stop_cond();
      #Q sda_m = 1'b0;
      #Q scl_m = 1'b1;
      #Q sda_m = 1'b1;
      #Q;
   endtask

   initial begin
      // Offset master activity from both clock edges.
      #2;
      rst_n = 1'b0;
      #100;
      check("rst_rx_data",  32'(rx_data),     32'h00);
      check("rst_rx_valid", 32'(rx_valid),    32'd0);
      check("rst_tx_req",   32'(tx_req),      32'd0);
      check("rst_busy",     32'(busy),        32'd0);
      check("rst_sda",      32'(sda),         32'd1);
      check("rst_state",    32'(dut.state_q), 32'(ST_IDLE));
      rst_n = 1'b1;
      #100;

      // Single-byte write
      v0 = rx_valid_cnt;
      start_cond();
      write_byte("wr_addr_ack", {7'h2A, 1'b1}, ACK);
      check("wr_busy", 32'(busy), 32'd1);
      rx_q.push_back(8'hA5);
      write_byte("wr_data_ack", 8'hA5, ACK);
      check("wr_busy_hold", 32'(busy), 32'd1);
      stop_cond();
      #Q;
      check("wr_rx_data",      32'(rx_data), 32'hA5);
      check("wr_rx_valid_cnt", 32'(rx_valid_cnt - v0), 32'd1);
      check("wr_busy_stop",    32'(busy), 32'd0);

      // Multi-byte write, repeated START, another write
      v0 = rx_valid_cnt;
      start_cond();
      write_byte("mb_addr_ack", {7'h2A, 1'b1}, ACK);
      rx_q.push_back(8'h12);
      write_byte("mb_d0_ack", 8'h12, ACK);
      rx_q.push_back(8'hED);
      write_byte("mb_d1_ack", 8'hED, ACK);
      start_cond();
      write_byte("rs_addr_ack", {7'h2A, 1'b1}, ACK);
      rx_q.push_back(8'h0F);
      write_byte("rs_d0_ack", 8'h0F, ACK);
      stop_cond();
      #Q;
      check("mb_rx_data",      32'(rx_data), 32'h0F);
      check("mb_rx_valid_cnt", 32'(rx_valid_cnt - v0), 32'd3);
      check("mb_state",        32'(dut.state_q), 32'(ST_IDLE));

      // Address mismatch
      v0 = rx_valid_cnt;
      d0 = dut_low_cnt;
      start_cond();
      write_byte("mm_addr_nack", {7'h15, 1'b1}, NACK);
      check("mm_busy", 32'(busy), 32'd0);
      write_byte("mm_data_nack", 8'h3C, NACK);
      stop_cond();
      check("mm_rx_valid_cnt", 32'(rx_valid_cnt - v0), 32'd0);
      check("mm_sda_driven",   32'(dut_low_cnt - d0), 32'd0);
      check("mm_rx_data",      32'(rx_data), 32'h0F);

      // Read two bytes: master ACK then NACK
      tx_data = 8'h81;
      rd_q.push_back(8'h81);
      t0 = tx_req_cnt;
      start_cond();
      write_byte("rd_addr_ack", {7'h2A, 1'b0}, ACK);
      #Q;
      check("rd_tx_req_first", 32'(tx_req_cnt - t0), 32'd1);
      tx_data = 8'h7E;
      rd_q.push_back(8'h7E);
      read_byte("rd_byte0", ACK);
      read_byte("rd_byte1", NACK);
      check("rd_state_wait", 32'(dut.state_q), 32'(ST_WAIT_STOP));
      check("rd_busy", 32'(busy), 32'd1);
      #Q;
      check("rd_sda_released", 32'(sda), 32'd1);
      stop_cond();
      check("rd_tx_req_cnt", 32'(tx_req_cnt - t0), 32'd2);
      check("rd_busy_stop",  32'(busy), 32'd0);

      // STOP in the middle of a data byte
      v0 = rx_valid_cnt;
      start_cond();
      write_byte("ab_addr_ack", {7'h2A, 1'b1}, ACK);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      stop_cond();
      #Q;
      check("ab_state",        32'(dut.state_q), 32'(ST_IDLE));
      check("ab_rx_data",      32'(rx_data), 32'h0F);
      check("ab_rx_valid_cnt", 32'(rx_valid_cnt - v0), 32'd0);
      check("ab_busy",         32'(busy), 32'd0);

      // Reset while the target holds the write ACK
      start_cond();
      write_byte("rs_wr_addr_ack", {7'h2A, 1'b1}, ACK);
      rx_q.push_back(8'h66);
      for (int i = 0; i < 8; i++) send_bit(byte66[i]);
      #Q sda_m = 1'b1;
      #10;
      check("rst_pre_ack", 32'(sda), 32'd0);
      #10 rst_n = 1'b0;
      #1;
      check("rst_mid_sda",      32'(sda),         32'd1);
      check("rst_mid_rx_data",  32'(rx_data),     32'h00);
      check("rst_mid_rx_valid", 32'(rx_valid),    32'd0);
      check("rst_mid_tx_req",   32'(tx_req),      32'd0);
      check("rst_mid_busy",     32'(busy),        32'd0);
      check("rst_mid_state",    32'(dut.state_q), 32'(ST_IDLE));
      #29 rst_n = 1'b1;
      #30 scl_m = 1'b1;
      #Q;
      #Q scl_m = 1'b0;
      v0 = rx_valid_cnt;
      write_byte("rst_ignored_nack", 8'h99, NACK);
      stop_cond();
      check("rst_after_rx_valid", 32'(rx_valid_cnt - v0), 32'd0);
      check("rst_after_rx_data",  32'(rx_data), 32'h00);
      check("rst_after_state",    32'(dut.state_q), 32'(ST_IDLE));

      // One-CLK SDA low glitch with SCL high
      #(4*Q);
      saw_addr = 1'b0;
      sda_m = 1'b0;
      #10 sda_m = 1'b1;
      #200;
`ifdef I2C_TGT_GLITCH_FILT_EN
      exp_glitch = 1'b0;
`else
      exp_glitch = 1'b1;
`endif
      check("glitch_start", 32'(saw_addr), 32'(exp_glitch));
      check("glitch_state", 32'(dut.state_q), 32'(ST_IDLE));

      check("rx_queue_empty",      32'(rx_q.size()), 32'd0);
      check("sda_moved_scl_high",  32'(illegal_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
